// File: rtl/systolic_feeder_4x4_if.sv
// Bundle between the systolic feeder and its host/array: the element write
// port, the start/busy/done handshake and the skewed row/column streams.
interface systolic_feeder_4x4_if #(
  parameter int DW = 8
);
  logic                 wr_en;
  logic                 wr_sel;
  logic [1:0]           wr_row;
  logic [1:0]           wr_col;
  logic signed [DW-1:0] wr_data;
  logic                 start;
  logic                 busy;
  logic                 array_clr;
  logic                 done;
  logic signed [DW-1:0] a1, a2, a3, a4;
  logic signed [DW-1:0] b1, b2, b3, b4;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  busy, array_clr, done, a1, a2, a3, a4, b1, b2, b3, b4
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output busy, array_clr, done, a1, a2, a3, a4, b1, b2, b3, b4
  );
endinterface

// File: rtl/systolic_feeder_4x4.sv
// Staging buffer and diagonal skew for a 4x4 output-stationary systolic array.
// Holds one A and one B matrix, clears the array, streams skewed rows/columns,
// then waits out the array drain before pulsing done.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | buffers writable, outputs 0, waiting for start
//   S_CLEAR  | one cycle, array_clr high to zero the accumulators
//   S_STREAM | 7 beats (t = 0..6) of diagonally skewed a/b streams
//   S_DRAIN  | DRAIN_CYCLES cycles of zero streams while the array settles
//   S_DONE   | one cycle, done high, array outputs final
module systolic_feeder_4x4 #(
  parameter int DW           = 8,
  parameter int DRAIN_CYCLES = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  systolic_feeder_4x4_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST_BEAT = 3'd6;
  localparam logic [3:0] DRAIN_TC  = 4'(DRAIN_CYCLES - 1);

  state_t               state;
  logic [2:0]           beat;
  logic [3:0]           drain_cnt;
  logic                 busy_q;
  logic                 clr_q;
  logic                 done_q;
  logic signed [DW-1:0] a_q [4];
  logic signed [DW-1:0] b_q [4];
  logic signed [DW-1:0] a_nxt [4];
  logic signed [DW-1:0] b_nxt [4];
  logic signed [DW-1:0] mem_a [4][4];
  logic signed [DW-1:0] mem_b [4][4];

  // Matrix buffers; writable only while idle so a running multiply sees a
  // frozen operand set. A write coincident with start still lands here
  // before the first beat reads the buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          mem_a[r][c] <= '0;
          mem_b[r][c] <= '0;
        end
      end
    end else if (state == S_IDLE && bus.wr_en) begin
      if (bus.wr_sel) mem_b[bus.wr_row][bus.wr_col] <= bus.wr_data;
      else            mem_a[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end

  // Skewed stream values for the beat about to be presented. Row i and
  // column j are delayed by i (j) beats; d is the matrix index after skew and
  // its top two bits being zero means it falls inside 0..3.
  always_comb begin
    logic       load_beat;
    logic [2:0] t_nxt;
    logic [3:0] d;
    load_beat = (state == S_CLEAR) || (state == S_STREAM && beat != LAST_BEAT);
    t_nxt     = (state == S_CLEAR) ? 3'd0 : beat + 3'd1;
    d         = '0;
    for (int i = 0; i < 4; i++) begin
      a_nxt[i] = '0;
      b_nxt[i] = '0;
      d = {1'b0, t_nxt} - 4'(i);
      if (load_beat && d[3:2] == 2'b00) begin
        a_nxt[i] = mem_a[i][d[1:0]];
        b_nxt[i] = mem_b[d[1:0]][i];
      end
    end
  end

  // Sequencer with registered handshake and stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      beat      <= '0;
      drain_cnt <= '0;
      busy_q    <= 1'b0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= a_nxt[i];
        b_q[i] <= b_nxt[i];
      end
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_CLEAR;
            clr_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          state <= S_STREAM;
          beat  <= '0;
        end
        S_STREAM: begin
          if (beat == LAST_BEAT) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_TC;
          end else begin
            beat <= beat + 3'd1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.array_clr = clr_q;
  assign bus.done      = done_q;
  assign bus.a1        = a_q[0];
  assign bus.a2        = a_q[1];
  assign bus.a3        = a_q[2];
  assign bus.a4        = a_q[3];
  assign bus.b1        = b_q[0];
  assign bus.b2        = b_q[1];
  assign bus.b3        = b_q[2];
  assign bus.b4        = b_q[3];

endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Directed bench for systolic_feeder_4x4 with a behavioural 4x4
// output-stationary array attached to the streams.
module tb_systolic_feeder_4x4;

  logic clk;
  logic rst_n;

  systolic_feeder_4x4_if #(.DW(8)) bus ();

  systolic_feeder_4x4 #(.DW(8), .DRAIN_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks;
  int n_errors;

  // per-cycle record of one operation, index = cycle number after start
  int a_h [32][4];
  int b_h [32][4];
  int clr_h [32];
  int busy_h [32];
  int done_cnt;
  int done_cyc;

  int a_in [4];
  int b_in [4];
  int ar  [4][4];
  int br  [4][4];
  int acc [4][4];

  int exp1 [4][4] = '{'{70, 80, 90, 100}, '{96, 110, 124, 138},
                      '{122, 140, 158, 176}, '{148, 170, 192, 214}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    a_in[0] = int'(bus.a1);
    a_in[1] = int'(bus.a2);
    a_in[2] = int'(bus.a3);
    a_in[3] = int'(bus.a4);
    b_in[0] = int'(bus.b1);
    b_in[1] = int'(bus.b2);
    b_in[2] = int'(bus.b3);
    b_in[3] = int'(bus.b4);
  end

  function automatic int a_pe(int i, int j);
    return (j == 0) ? a_in[i] : ar[i][j-1];
  endfunction

  function automatic int b_pe(int i, int j);
    return (i == 0) ? b_in[j] : br[i-1][j];
  endfunction

  // downstream array: a moves right, b moves down, each PE accumulates
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.array_clr) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          ar[i][j]  <= 0;
          br[i][j]  <= 0;
          acc[i][j] <= 0;
        end
    end else begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          ar[i][j]  <= a_pe(i, j);
          br[i][j]  <= b_pe(i, j);
          acc[i][j] <= acc[i][j] + a_pe(i, j) * b_pe(i, j);
        end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic sel, input int r, input int c, input int val);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_row  = 2'(r);
    bus.wr_col  = 2'(c);
    bus.wr_data = 8'(val);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic load_ramp();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wr(1'b0, r, c, r + c + 1);
        wr(1'b1, r, c, r + c + 5);
      end
  endtask

  task automatic load_signed();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wr(1'b0, r, c, -128);
        wr(1'b1, r, c, 127);
      end
  endtask

  // Called at a negedge while idle. Any write fields preset by the caller go
  // in on the same edge as start. busy_wr_cyc/extra_start_cyc (0 = none)
  // inject a write of A[0][0]=99 or a stray start during that cycle.
  task automatic run_op(input int busy_wr_cyc, input int extra_start_cyc);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    done_cnt  = 0;
    done_cyc  = 0;
    for (int c = 1; c <= 24; c++) begin
      if (c > 1) @(negedge clk);
      a_h[c][0] = int'(bus.a1); a_h[c][1] = int'(bus.a2);
      a_h[c][2] = int'(bus.a3); a_h[c][3] = int'(bus.a4);
      b_h[c][0] = int'(bus.b1); b_h[c][1] = int'(bus.b2);
      b_h[c][2] = int'(bus.b3); b_h[c][3] = int'(bus.b4);
      clr_h[c]  = int'(bus.array_clr);
      busy_h[c] = int'(bus.busy);
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      if (c == busy_wr_cyc) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = 2'd0;
        bus.wr_col  = 2'd0;
        bus.wr_data = 8'd99;
      end
      if (c == extra_start_cyc) bus.start = 1'b1;
    end
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic chk_all_acc(input string tag, input int v);
    int bad;
    bad = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (acc[i][j] != v) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic chk_ramp_results(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (acc[i][j] != exp1[i][j]) begin
          bad++;
          $display("  c%0d%0d = %0d (want %0d)", i + 1, j + 1, acc[i][j], exp1[i][j]);
        end
    chk(tag, bad, 0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_row  = 2'd0;
    bus.wr_col  = 2'd0;
    bus.wr_data = 8'd0;
    bus.start   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_clr", int'(bus.array_clr), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_streams", int'(|{bus.a1, bus.a2, bus.a3, bus.a4, bus.b1, bus.b2, bus.b3, bus.b4}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ramp operands: timing, skew and product
    load_ramp();
    run_op(0, 0);
    chk("t1_clr_c1", clr_h[1], 1);
    chk("t1_clr_c2", clr_h[2], 0);
    chk("t1_busy_c1", busy_h[1], 1);
    chk("t1_busy_c17", busy_h[17], 1);
    chk("t1_busy_c18", busy_h[18], 0);
    chk("t1_done_cyc", done_cyc, 17);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_c2_a1", a_h[2][0], 1);
    chk("t1_c2_b1", b_h[2][0], 5);
    chk("t1_c2_rest", a_h[2][1] | a_h[2][2] | a_h[2][3] | b_h[2][1] | b_h[2][2] | b_h[2][3], 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_c5_a%0d", i + 1), a_h[5][i], 4);
      chk($sformatf("t1_c5_b%0d", i + 1), b_h[5][i], 8);
    end
    chk("t1_c8_a4", a_h[8][3], 7);
    chk("t1_c8_b4", b_h[8][3], 11);
    chk("t1_c8_rest", a_h[8][0] | a_h[8][1] | a_h[8][2] | b_h[8][0] | b_h[8][1] | b_h[8][2], 0);
    chk("t1_c9_zero", a_h[9][0] | a_h[9][3] | b_h[9][0] | b_h[9][3], 0);
    chk_ramp_results("t1_results");

    // signed extremes, then a rerun without reload
    load_signed();
    run_op(0, 0);
    chk_all_acc("t2_signed_run1", -65024);
    run_op(0, 0);
    chk_all_acc("t2_signed_run2", -65024);
    chk("t2_done_cyc", done_cyc, 17);

    // write and stray start while busy are both dropped
    run_op(4, 6);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_done_cyc", done_cyc, 17);
    chk("t3_c2_a1", a_h[2][0], -128);
    chk_all_acc("t3_results", -65024);
    run_op(0, 0);
    chk("t3_a00_kept", a_h[2][0], -128);

    // write committed on the same edge that accepts start
    bus.wr_en   = 1'b1;
    bus.wr_sel  = 1'b0;
    bus.wr_row  = 2'd3;
    bus.wr_col  = 2'd3;
    bus.wr_data = 8'd10;
    run_op(0, 0);
    chk("t4_c8_a4", a_h[8][3], 10);
    chk("t4_c8_b4", b_h[8][3], 127);

    // asynchronous reset mid-stream
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_busy_before", int'(bus.busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_streams", int'(|{bus.a1, bus.a2, bus.a3, bus.a4, bus.b1, bus.b2, bus.b3, bus.b4}), 0);
    chk("t5_clr_done", int'(bus.array_clr | bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0, 0);
    chk("t5_storage_cleared", a_h[5][0] | a_h[5][3] | b_h[5][0] | b_h[5][3], 0);
    chk("t5_empty_done", done_cyc, 17);
    load_ramp();
    run_op(0, 0);
    chk("t5_reload_done", done_cyc, 17);
    chk_ramp_results("t5_reload_results");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/systolic_feeder_4x4.md
# systolic_feeder_4x4

Input-staging and skew stage that sits directly upstream of the 4x4 output-stationary systolic array. It buffers one 4x4 signed 8-bit A matrix and one 4x4 B matrix written over a simple register port. On `start` it clears the array accumulators, then drives the diagonally skewed row streams `a1..a4` and column streams `b1..b4` the array consumes. It then waits out the array's drain latency and pulses `done` when `c11..c44` hold the full product A×B.

## Interface
Parameters:
- `DW`, 8 — element width, signed two's complement.
- `DRAIN_CYCLES`, 8 — zero-input cycles after the last skewed beat before `done`; legal range 4..15.

Ports:
- `clk`  in  1  — single clock, all logic on rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `wr_en`  in  1  — write one matrix element this cycle.
- `wr_sel`  in  1  — 0 = matrix A, 1 = matrix B.
- `wr_row`  in  2  — row index, 0..3.
- `wr_col`  in  2  — column index, 0..3.
- `wr_data`  in  DW  — element value, signed.
- `start`  in  1  — request one multiply; sampled only in IDLE.
- `busy`  out  1  — high from the cycle after `start` is accepted through the `done` cycle inclusive.
- `array_clr`  out  1  — one-cycle pulse; top level ORs it into the array reset to zero the accumulators.
- `a1..a4`  out  DW each  — row streams to array rows 1..4, registered.
- `b1..b4`  out  DW each  — column streams to array columns 1..4, registered.
- `done`  out  1  — one-cycle pulse; array outputs are final and stable while the array is idle.

## Operation
Storage:
- Two 16-entry arrays of `DW` bits, A[r][c] and B[r][c]; all entries reset to 0.
- A write lands at the clock edge when `wr_en` = 1 and the state is IDLE.
- Writes in any other state are dropped silently; storage is unchanged.

FSM states: IDLE → CLEAR → STREAM → DRAIN → DONE → IDLE.
- IDLE: outputs 0, `busy` = 0. If `start` = 1, go to CLEAR. A same-cycle `wr_en` is also committed, and the stream uses the updated value.
- CLEAR: one cycle; `array_clr` = 1; streams are 0.
- STREAM: 7 cycles, beat counter t = 0..6.
  - For row i (1..4): `a_i` = A[i-1][t-(i-1)] when 0 ≤ t-(i-1) ≤ 3, else 0.
  - For column j (1..4): `b_j` = B[t-(j-1)][j-1] when 0 ≤ t-(j-1) ≤ 3, else 0.
- DRAIN: `DRAIN_CYCLES` cycles with all streams 0.
- DONE: one cycle; `done` = 1 and `busy` = 1. Then IDLE.
- `start` outside IDLE is ignored and is not queued.
- Stream values pass through unmodified with no arithmetic; `array_clr` goes only to the accumulators, never to the buffers.

Reset:
- Asserting `rst_n` low at any time, including mid-STREAM, forces IDLE immediately.
- All outputs go to 0 and all storage clears.
- There is no partial-result guarantee for an operation interrupted by reset.

## Timing
- Number cycles 1, 2, … after the edge at which IDLE samples `start` = 1.
- Cycle 1: `array_clr` = 1.
- Cycles 2–8: STREAM beats t = 0..6.
- Cycles 9 .. 8+`DRAIN_CYCLES`: DRAIN.
- Cycle 9+`DRAIN_CYCLES`: `done` = 1; with default DRAIN this is cycle 17.
- `busy` is high during cycles 1 .. 9+`DRAIN_CYCLES`.
- Next accepted `start` is no earlier than the cycle after DONE, i.e. back-to-back spacing of 10+`DRAIN_CYCLES` cycles.
- All outputs are driven from flops; there is no combinational path from any input to any output.
- Reset values: `busy`, `array_clr`, `done`, `a1..a4` and `b1..b4` are all 0.

## Test plan
- Load A[r][c] = r+c+1 and B[r][c] = r+c+5, pulse `start`, connect to the array. Required: `done` at cycle 17. Array results are rows 70 80 90 100 / 96 110 124 138 / 122 140 158 176 / 148 170 192 214.
- Skew check on the same load:
  - Cycle 2: `a1` = 1, `b1` = 5, others 0.
  - Cycle 5: `a1..a4` = 4,4,4,4 and `b1..b4` = 8,8,8,8.
  - Cycle 8: `a4` = 7, `b4` = 11, others 0.
- Signed data: A = all -128, B = all 127. Required: every c = -65024. Then run a second `start` with no reload; results must be identical, proving `array_clr` took effect.
- Writes while busy: during cycle 4, write A[0][0] = 99. Required: the stream still uses the old value and A[0][0] is unchanged afterwards. A `start` pulse at cycle 6 is ignored, so `done` fires once.
- Same-cycle write and start in IDLE: `wr_en` writing A[3][3] = 10 together with `start`. Required: `a4` = 10 at cycle 8.
- Async reset: drive `rst_n` low mid-cycle at cycle 5. Required: all outputs 0 before the next edge and `busy` = 0. After release, a full reload and `start` complete normally.
